fifo_unpacker: RTL and testbench
================================

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning FIFO word width (bits).
REQ-002 SHALL have parameter OWIDTH, default 16, meaning output beat width (bits).
REQ-003 SHALL have parameter LSB_FIRST, default 1, meaning 1 = emit the least-significant segment first, 0 = the most-significant first.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port arstn_i, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port fifo_q_i, input, DWIDTH bits, showahead FIFO head word, valid while fifo_empty_i=0.
REQ-007 SHALL have port fifo_empty_i, input, 1 bit, FIFO empty flag.
REQ-008 SHALL have port fifo_rdreq_o, output, 1 bit, acknowledges/pops the FIFO head in the same cycle.
REQ-009 SHALL have port data_o, output, OWIDTH bits, output beat.
REQ-010 SHALL have port valid_o, output, 1 bit, data_o/last_o valid.
REQ-011 SHALL have port ready_i, input, 1 bit, downstream accepts the beat.
REQ-012 SHALL have port last_o, output, 1 bit, marks the final segment of the current FIFO word.

Function
REQ-013 SHALL define RATIO = DWIDTH/OWIDTH and fail elaboration unless DWIDTH % OWIDTH = 0 and RATIO >= 2.
REQ-014 SHALL hold a DWIDTH holding register, a segment counter cnt (width $clog2(RATIO), range 0..RATIO-1) and a two-state FSM: EMPTY (no word held), BUSY (word held, valid_o=1).
REQ-015 SHALL define beat transfer as valid_o && ready_i in the same cycle.
REQ-016 SHALL assert fifo_rdreq_o = !fifo_empty_i && (state=EMPTY || (transfer && cnt=RATIO-1)), and never while fifo_empty_i=1.
REQ-017 SHALL, on fifo_rdreq_o, load fifo_q_i into the holding register, set cnt=0 and enter BUSY at the next edge (load-to-valid latency: 1 cycle).
REQ-018 SHALL, on a transfer with cnt<RATIO-1, increment cnt and stay BUSY.
REQ-019 SHALL, on a transfer with cnt=RATIO-1 and no simultaneous load, enter EMPTY (valid_o=0 the next cycle).
REQ-020 SHALL, on a transfer with cnt=RATIO-1 and a simultaneous load, stay BUSY with cnt=0, giving zero-bubble throughput across words.
REQ-021 SHALL drive valid_o = (state=BUSY) and last_o = valid_o && cnt=RATIO-1.
REQ-022 SHALL drive data_o with segment cnt of the holding register when LSB_FIRST=1, or segment RATIO-1-cnt when LSB_FIRST=0.
REQ-023 SHALL hold data_o, last_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL ignore ready_i while valid_o=0.

Reset
REQ-025 SHALL, while arstn_i=0, asynchronously force state=EMPTY, cnt=0, valid_o=0, last_o=0 and holding register=0.
REQ-026 SHALL gate fifo_rdreq_o to 0 while arstn_i=0, whatever fifo_empty_i is.
REQ-027 SHALL discard the remaining segments of any word held when reset asserts mid-word; that word is lost.
REQ-028 SHALL treat arstn_i deassertion as synchronous to clk_i; it is synchronised externally.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, BUSY) in shared package fifo_unpacker_pkg.
REQ-030 SHALL compute RATIO and the counter width as localparams inside the module.
REQ-031 SHALL be a single module with no sub-module; it connects directly to fifo with SHOWAHEAD=1, REGISTER_OUTPUT=0.

Verification (DWIDTH=64, OWIDTH=16)
REQ-032 SHALL cover: reset held with fifo_empty_i=0 -> fifo_rdreq_o=0, valid_o=0 throughout reset.
REQ-033 SHALL cover: one word 0x4444_3333_2222_1111, ready_i=1, LSB_FIRST=1 -> rdreq pulses once; beats 0x1111, 0x2222, 0x3333, 0x4444 on cycles 1-4 after rdreq; last_o only on 0x4444; then valid_o=0.
REQ-034 SHALL cover: same word with LSB_FIRST=0 -> beats 0x4444, 0x3333, 0x2222, 0x1111.
REQ-035 SHALL cover: two queued words, ready_i=1 -> 8 consecutive valid beats with no bubble; second rdreq coincides with beat 4.
REQ-036 SHALL cover: ready_i low for 3 cycles at beat 0x2222 -> data_o=0x2222 and valid_o=1 held; 0x3333 follows the first ready cycle.
REQ-037 SHALL cover: arstn_i pulsed low after beat 0x2222 while the FIFO holds one more word -> valid_o=0 during reset; after release, the next word is loaded with 1-cycle latency and 0x3333/0x4444 never appear.

Source files
------------

// File: rtl/fifo_unpacker_pkg.sv
// Shared definitions for the FIFO word unpacker.
package fifo_unpacker_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

endpackage : fifo_unpacker_pkg

// File: rtl/fifo_unpacker.sv
// Splits each word popped from a showahead FIFO into RATIO narrower beats on a
// valid/ready stream, refilling on the last beat so consecutive words have no bubble.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int OWIDTH    = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [OWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int RATIO = DWIDTH / OWIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if ((DWIDTH % OWIDTH) != 0 || RATIO < 2) begin : g_bad_params
      $error("fifo_unpacker: DWIDTH must be a multiple of OWIDTH with a ratio of at least 2");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  seg_idx;
  logic              xfer;
  logic              at_last;

  assign xfer    = valid_o && ready_i;
  assign at_last = (cnt_q == CNT_LAST);

  // Gated by reset so an upstream FIFO never loses a word while we are held in reset.
  assign fifo_rdreq_o = arstn_i && !fifo_empty_i &&
                        ((state_q == EMPTY) || (xfer && at_last));

  assign valid_o = (state_q == BUSY);
  assign last_o  = valid_o && at_last;
  assign seg_idx = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
  assign data_o  = hold_q[seg_idx*OWIDTH +: OWIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (xfer) begin
      if (at_last) begin
        state_d = EMPTY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A load on the final beat overrides the drop to EMPTY for back-to-back words.
    if (fifo_rdreq_o) begin
      hold_d  = fifo_q_i;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      // NOTE: the holding register is a plain register, not a memory, so clearing it on reset is cheap and keeps data_o deterministic.
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule : fifo_unpacker

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench for fifo_unpacker: one LSB-first and one MSB-first instance
// share a modelled showahead FIFO; a negedge monitor checks every beat.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] fifo_q;
  logic        fifo_empty;
  logic        ready;
  logic        rdreq_l, rdreq_m;
  logic [15:0] data_l, data_m;
  logic        valid_l, valid_m, last_l, last_m;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] fifo_mem[$];
  logic [16:0] exp_l[$];
  logic [16:0] exp_m[$];
  int          rd_cyc[$];
  int          xfer_cyc[$];
  logic        rd_prev_l = 1'b0;
  logic        rd_prev_m = 1'b0;

  always #5 clk = ~clk;

  fifo_unpacker #(.DWIDTH(64), .OWIDTH(16), .LSB_FIRST(1'b1)) dut_l (
    .clk_i(clk), .arstn_i(rst_n), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(rdreq_l), .data_o(data_l), .valid_o(valid_l),
    .ready_i(ready), .last_o(last_l)
  );

  fifo_unpacker #(.DWIDTH(64), .OWIDTH(16), .LSB_FIRST(1'b0)) dut_m (
    .clk_i(clk), .arstn_i(rst_n), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(rdreq_m), .data_o(data_m), .valid_o(valid_m),
    .ready_i(ready), .last_o(last_m)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = (fifo_mem.size() == 0) ? 64'h0 : fifo_mem[0];
  endtask

  // Pushing a word also pushes its hand-ordered expected beats for both instances.
  task automatic push_word(input logic [63:0] w);
    logic [63:0] tmp;
    tmp = w;
    fifo_mem.push_back(w);
    for (int i = 0; i < 4; i++) begin
      exp_l.push_back({(i == 3), tmp[i*16 +: 16]});
      exp_m.push_back({(i == 3), tmp[(3-i)*16 +: 16]});
    end
    refresh_fifo();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!valid_l && !valid_m && fifo_mem.size() == 0 &&
          exp_l.size() == 0 && exp_m.size() == 0)
        done = 1'b1;
    end
    check("idle_reached", done, 1'b1);
  endtask

  task automatic wait_show_2222();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      next_cycle();
      if (valid_l && data_l == 16'h2222) seen = 1'b1;
    end
    check("saw_2222", seen, 1'b1);
  endtask

  // FIFO model: pop just after the edge on which the DUT sampled rdreq.
  always @(posedge clk) begin
    if (rdreq_l) begin
      #1;
      if (fifo_mem.size() > 0) void'(fifo_mem.pop_front());
      refresh_fifo();
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (!rst_n) begin
      check("rst_rdreq_l", rdreq_l, 1'b0);
      check("rst_rdreq_m", rdreq_m, 1'b0);
      check("rst_valid_l", valid_l, 1'b0);
      check("rst_valid_m", valid_m, 1'b0);
      check("rst_last_l", last_l, 1'b0);
    end else begin
      if (fifo_empty) check("rdreq_while_empty", rdreq_l, 1'b0);
      if (rd_prev_l) check("load_latency_l", valid_l, 1'b1);
      if (rd_prev_m) check("load_latency_m", valid_m, 1'b1);
      if (rdreq_l) rd_cyc.push_back(cyc);
      if (valid_l && ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_l.size() == 0) check("unexpected_beat_l", {last_l, data_l}, 17'h0);
        else begin
          e = exp_l.pop_front();
          check("beat_l", {last_l, data_l}, e);
        end
      end
      if (valid_m && ready) begin
        if (exp_m.size() == 0) check("unexpected_beat_m", {last_m, data_m}, 17'h0);
        else begin
          e = exp_m.pop_front();
          check("beat_m", {last_m, data_m}, e);
        end
      end
    end
    rd_prev_l = rst_n && rdreq_l;
    rd_prev_m = rst_n && rdreq_m;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    ready = 1'b1;
    refresh_fifo();

    // Reset held with a word waiting: nothing may be popped or presented.
    push_word(64'h4444_3333_2222_1111);
    repeat (3) next_cycle();
    rd_cyc.delete();
    xfer_cyc.delete();
    rst_n = 1'b1;

    // Single word, continuous ready: four beats right after the lone rdreq.
    wait_idle();
    check("w1_rdreq_count", rd_cyc.size(), 1);
    check("w1_beat_count", xfer_cyc.size(), 4);
    if (rd_cyc.size() >= 1 && xfer_cyc.size() >= 4)
      for (int i = 0; i < 4; i++)
        check("w1_beat_cycle", xfer_cyc[i], rd_cyc[0] + 1 + i);
    check("w1_valid_after", valid_l, 1'b0);

    // Two queued words: eight beats with no bubble, second pop on beat 4.
    next_cycle();
    rd_cyc.delete();
    xfer_cyc.delete();
    push_word(64'h8888_7777_6666_5555);
    push_word(64'hDDDD_CCCC_BBBB_AAAA);
    wait_idle();
    check("w2_rdreq_count", rd_cyc.size(), 2);
    check("w2_beat_count", xfer_cyc.size(), 8);
    if (rd_cyc.size() >= 2 && xfer_cyc.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        check("w2_no_bubble", xfer_cyc[i], rd_cyc[0] + 1 + i);
      check("w2_second_pop_on_beat4", rd_cyc[1], xfer_cyc[3]);
    end

    // Backpressure: three stalled cycles on 0x2222 hold the beat steady.
    next_cycle();
    push_word(64'h4444_3333_2222_1111);
    wait_show_2222();
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_data_l", data_l, 16'h2222);
      check("stall_valid_l", valid_l, 1'b1);
      check("stall_data_m", data_m, 16'h3333);
    end
    next_cycle();
    ready = 1'b1;
    next_cycle();
    check("after_stall_data_l", data_l, 16'h3333);
    wait_idle();

    // Reset mid-word: the rest of the held word is lost, the next word loads cleanly.
    next_cycle();
    push_word(64'h4444_3333_2222_1111);
    push_word(64'hFFFF_EEEE_9999_0000);
    wait_show_2222();
    next_cycle();
    rst_n = 1'b0;
    repeat (2) begin
      void'(exp_l.pop_front());
      void'(exp_m.pop_front());
    end
    rd_cyc.delete();
    xfer_cyc.delete();
    @(negedge clk);
    check("midreset_fifo_kept", fifo_empty, 1'b0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    c0 = cyc;
    wait_idle();
    check("rst_rdreq_count", rd_cyc.size(), 1);
    check("rst_beat_count", xfer_cyc.size(), 4);
    if (rd_cyc.size() >= 1 && xfer_cyc.size() >= 1) begin
      check("rst_reload_cycle", rd_cyc[0], c0 + 1);
      check("rst_first_beat_cycle", xfer_cyc[0], c0 + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_unpacker
